// File: rtl/bbuf_loader.sv
// bbuf_loader: descriptor-driven stream-to-bias-buffer write feeder.
// Optional statistics ports enabled by defining BBUF_LOADER_STATS_EN.
module bbuf_loader #(
   parameter int MEM_DATA_WIDTH = 64,
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int COUNT_W        = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [MEM_ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [COUNT_W-1:0]        cfg_num_words,
   input  logic [MEM_ADDR_WIDTH-1:0] cfg_addr_stride,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [MEM_DATA_WIDTH-1:0] s_data,
   input  logic                      s_last,
   output logic                      mem_write_req,
   output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
   output logic [MEM_DATA_WIDTH-1:0] mem_write_data,
   output logic                      busy,
   output logic                      done,
   output logic                      err_last
`ifdef BBUF_LOADER_STATS_EN
   ,
   output logic [COUNT_W-1:0]        stat_stall_cycles,
   output logic [COUNT_W-1:0]        stat_words
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                    state;
   logic [MEM_ADDR_WIDTH-1:0] cur_addr;
   logic [MEM_ADDR_WIDTH-1:0] stride;
   logic [COUNT_W-1:0]        remaining;
   logic                      cfg_acc;
   logic                      beat_acc;
   logic                      last_beat;

   // handshake readiness depends on state only
   assign cfg_ready = (state == IDLE);
   assign s_ready   = (state == LOAD);
   assign busy      = (state != IDLE);
   assign cfg_acc   = cfg_valid && cfg_ready;
   assign beat_acc  = s_valid && s_ready;
   assign last_beat = (remaining == COUNT_W'(1));

   // transfer FSM with registered write port, done pulse and framing error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         cur_addr       <= '0;
         stride         <= '0;
         remaining      <= '0;
         mem_write_req  <= 1'b0;
         mem_write_addr <= '0;
         mem_write_data <= '0;
         done           <= 1'b0;
         err_last       <= 1'b0;
      end else begin
         mem_write_req <= 1'b0;
         done          <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cfg_valid) begin
                  cur_addr  <= cfg_base_addr;
                  stride    <= cfg_addr_stride;
                  remaining <= cfg_num_words;
                  err_last  <= 1'b0;
                  if (cfg_num_words != '0) begin
                     state <= LOAD;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (s_valid) begin
                  mem_write_req  <= 1'b1;
                  mem_write_addr <= cur_addr;
                  mem_write_data <= s_data;
                  cur_addr       <= cur_addr + stride;
                  remaining      <= remaining - COUNT_W'(1);
                  if (s_last != last_beat) begin
                     err_last <= 1'b1;
                  end
                  if (last_beat) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef BBUF_LOADER_STATS_EN
   // saturating per-transfer stall and word counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_stall_cycles <= '0;
         stat_words        <= '0;
      end else if (cfg_acc) begin
         stat_stall_cycles <= '0;
         stat_words        <= '0;
      end else if (state == LOAD) begin
         if (!s_valid && (stat_stall_cycles != '1)) begin
            stat_stall_cycles <= stat_stall_cycles + COUNT_W'(1);
         end
         if (beat_acc && (stat_words != '1)) begin
            stat_words <= stat_words + COUNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_bbuf_loader.sv
// tb_bbuf_loader: randomized bench for bbuf_loader against a
// transfer-level reference model (address = base + k*stride mod 2^AW).
module tb_bbuf_loader;

   localparam int DW = 64;
   localparam int AW = 10;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [AW-1:0] cfg_base_addr;
   logic [CW-1:0] cfg_num_words;
   logic [AW-1:0] cfg_addr_stride;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          mem_write_req;
   logic [AW-1:0] mem_write_addr;
   logic [DW-1:0] mem_write_data;
   logic          busy;
   logic          done;
   logic          err_last;
`ifdef BBUF_LOADER_STATS_EN
   logic [CW-1:0] stat_stall_cycles;
   logic [CW-1:0] stat_words;
`endif

   bbuf_loader #(
      .MEM_DATA_WIDTH(DW),
      .MEM_ADDR_WIDTH(AW),
      .COUNT_W(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_base_addr(cfg_base_addr),
      .cfg_num_words(cfg_num_words),
      .cfg_addr_stride(cfg_addr_stride),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data(s_data),
      .s_last(s_last),
      .mem_write_req(mem_write_req),
      .mem_write_addr(mem_write_addr),
      .mem_write_data(mem_write_data),
      .busy(busy),
      .done(done),
      .err_last(err_last)
`ifdef BBUF_LOADER_STATS_EN
      ,
      .stat_stall_cycles(stat_stall_cycles),
      .stat_words(stat_words)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference model: phase 0 idle, 1 load, 2 done
   int            ph = 0;
   int            m_base, m_stride, m_num, m_k;
   logic          m_req = 1'b0;
   logic          m_err = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   int            m_stall = 0;
   int            m_words = 0;

   // advance the model by the clock edge just taken, then compare
   task automatic step(output bit acc, output bit cacc);
      acc   = 1'b0;
      cacc  = 1'b0;
      m_req = 1'b0;
      case (ph)
         0: begin
            if (cfg_valid) begin
               cacc     = 1'b1;
               m_base   = int'(cfg_base_addr);
               m_stride = int'(cfg_addr_stride);
               m_num    = int'(cfg_num_words);
               m_k      = 0;
               m_err    = 1'b0;
               m_stall  = 0;
               m_words  = 0;
               ph       = (m_num != 0) ? 1 : 2;
            end
         end
         1: begin
            if (s_valid) begin
               acc    = 1'b1;
               m_req  = 1'b1;
               m_addr = AW'((m_base + m_k * m_stride) % (1 << AW));
               m_data = s_data;
               if (s_last != (m_k == m_num - 1)) m_err = 1'b1;
               m_k++;
               if (m_words < (1 << CW) - 1) m_words++;
               if (m_k == m_num) ph = 2;
            end else begin
               if (m_stall < (1 << CW) - 1) m_stall++;
            end
         end
         default: ph = 0;
      endcase
      check("req", mem_write_req, m_req);
      check("addr", mem_write_addr, m_addr);
      check("data", mem_write_data, m_data);
      check("done", done, ph == 2);
      check("busy", busy, ph != 0);
      check("cfg_ready", cfg_ready, ph == 0);
      check("s_ready", s_ready, ph == 1);
      check("err_last", err_last, m_err);
`ifdef BBUF_LOADER_STATS_EN
      check("stat_stall", stat_stall_cycles, m_stall);
      check("stat_words", stat_words, m_words);
`endif
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      cfg_valid = 1'b0;
      s_valid   = 1'b0;
      s_last    = 1'b0;
      #1;
      ph      = 0;
      m_req   = 1'b0;
      m_err   = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      m_stall = 0;
      m_words = 0;
      check("rst_req", mem_write_req, 0);
      check("rst_addr", mem_write_addr, 0);
      check("rst_data", mem_write_data, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_last, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_cfg_ready", cfg_ready, 1);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // one descriptor plus its beats; vpct<0 alternates s_valid
   task automatic run(input int base, input int num, input int stride,
                      input int vpct, input int bad, input int abort_at,
                      input logic [63:0] d0, input bit rnd);
      logic [DW-1:0] beats[$];
      int            sent;
      int            guard;
      bit            acc, cacc, cfg_seen, fin;
      for (int i = 0; i < num; i++)
         beats.push_back(rnd ? {$urandom, $urandom} : d0 + 64'(i));
      cfg_valid       = 1'b1;
      cfg_base_addr   = AW'(base);
      cfg_num_words   = CW'(num);
      cfg_addr_stride = AW'(stride);
      sent     = 0;
      guard    = 0;
      cfg_seen = 1'b0;
      fin      = 1'b0;
      if (num > 0) begin
         s_valid = (vpct < 0) ? 1'b1 : ($urandom_range(99) < vpct);
         s_data  = beats[0];
         s_last  = (bad >= 0) ? (bad == 0) : (num == 1);
      end
      while (!fin && guard < 300) begin
         @(negedge clk);
         guard++;
         step(acc, cacc);
         if (cacc) begin
            cfg_seen  = 1'b1;
            cfg_valid = 1'b0;
         end
         if (acc) sent++;
         if (abort_at > 0 && sent == abort_at) begin
            do_reset();
            fin = 1'b1;
         end else if (cfg_seen && ph == 0) begin
            fin = 1'b1;
         end else if (s_valid && !acc) begin
            s_valid = 1'b1;
         end else if (sent < num) begin
            s_valid = (vpct < 0) ? !s_valid : ($urandom_range(99) < vpct);
            s_data  = beats[sent];
            s_last  = (bad >= 0) ? (sent == bad) : (sent == num - 1);
         end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
         end
      end
      if (!fin) check("timeout", 0, 1);
      cfg_valid = 1'b0;
      s_valid   = 1'b0;
      s_last    = 1'b0;
   endtask

   initial begin
      int n;
      reset           = 1'b0;
      cfg_valid       = 1'b0;
      cfg_base_addr   = '0;
      cfg_num_words   = '0;
      cfg_addr_stride = '0;
      s_valid         = 1'b0;
      s_data          = '0;
      s_last          = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req", mem_write_req, 0);
      check("rst_busy", busy, 0);
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_s_ready", s_ready, 0);
      reset = 1'b1;
      @(negedge clk);
      run(0, 4, 1, 100, -1, 0, 64'hA, 1'b0);
      run(1022, 4, 1, 100, -1, 0, 64'h100, 1'b0);
      run(7, 0, 1, 100, -1, 0, 64'h0, 1'b0);
      run(20, 3, 1, -1, -1, 0, 64'h0, 1'b1);
`ifdef BBUF_LOADER_STATS_EN
      check("alt_stall", stat_stall_cycles, 2);
      check("alt_words", stat_words, 3);
`endif
      run(40, 3, 1, 100, 1, 0, 64'h55, 1'b0);
      check("err_sticky", err_last, 1);
      run(60, 2, 3, 100, -1, 0, 64'h0, 1'b1);
      check("err_cleared", err_last, 0);
      run(100, 8, 2, 100, -1, 3, 64'h0, 1'b1);
      run(5, 1, 1, 100, -1, 0, 64'hBEEF, 1'b0);
      for (int t = 0; t < 30; t++) begin
         n = $urandom_range(6);
         run($urandom_range(1023), n, $urandom_range(1023),
             $urandom_range(30, 100),
             ($urandom_range(3) == 0 && n > 0) ? $urandom_range(n - 1) : -1,
             0, 64'h0, 1'b1);
         repeat ($urandom_range(2)) begin
            @(negedge clk);
            begin
               bit a, c;
               step(a, c);
            end
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
